scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder_pkg.sv | 5 +
 rtl/scan_decoder_onehot_dec.sv | 11 +
 rtl/scan_decoder.sv | 55 +++++
 tb/tb_scan_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: state encoding and default index width shared by scan_decoder files.
package scan_decoder_pkg;
   typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;
   localparam int SEL_W_DEF = 2;
endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// onehot_dec: combinational active-low one-hot decoder; all ones when disabled.
module onehot_dec #(
   parameter int SEL_W = 2
) (
   input  logic                  en,
   input  logic [SEL_W-1:0]      index,
   output logic [2**SEL_W-1:0]   y_n
);
   localparam int OUT_W = 2**SEL_W;
   assign y_n = en ? ~(OUT_W'(1) << index) : '1;
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered direct/auto-scan one-hot-low decoder.
// Define SCAN_DECODER_BLANK_EN for one all-ones blank cycle on every scan index change.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  G_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  load,
   input  logic                  tick,
   output logic [2**SEL_W-1:0]   Y_n,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);
   localparam int OUT_W = 2**SEL_W;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_W - 1);
   state_t state, nxt;
   logic [SEL_W-1:0] idx_d;
   logic [OUT_W-1:0] dec_n;
   logic wrap_d, step, en, blank, blank_d;
   // outputs are decoded from the next state so they land on the same edge as idx
   always_comb begin
      nxt = G_n ? IDLE : (mode ? SCAN : DECODE);
      step = nxt == SCAN && !load && tick && !(state == SCAN && blank);
      idx_d = (nxt == DECODE || (nxt == SCAN && load)) ? sel : (step ? SEL_W'(idx + 1'b1) : idx);
      wrap_d = step && idx == LAST;
      en = nxt != IDLE && !blank_d;
   end
`ifdef SCAN_DECODER_BLANK_EN
   assign blank_d = nxt == SCAN && (load || step);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) blank <= 1'b0;
      else blank <= blank_d;
`else
   assign blank_d = 1'b0;
   assign blank = 1'b0;
`endif
   onehot_dec #(.SEL_W(SEL_W)) u_dec (.en(en), .index(idx_d), .y_n(dec_n));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         wrap <= 1'b0;
         Y_n <= '1;
      end else begin
         state <= nxt;
         idx <= idx_d;
         wrap <= wrap_d;
         Y_n <= dec_n;
      end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: randomized and directed scoreboard bench for scan_decoder at SEL_W=2 and SEL_W=3.
module tb_scan_decoder;
`ifdef SCAN_DECODER_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   typedef struct packed {logic [7:0] y; logic [2:0] idx; logic wrap;} exp_t;
   typedef struct packed {exp_t a; exp_t b;} pair_t;
   logic clk = 0, rst_n = 0, g_n = 1, mode = 0, load = 0, tick = 0;
   logic [1:0] sel = 0;
   logic [2:0] sel3 = 0;
   logic [3:0] y4;
   logic [1:0] idx4;
   logic wrap4;
   logic [7:0] y8;
   logic [2:0] idx8;
   logic wrap8;
   int n_vec = 0, n_bad = 0, wraps;
   int m_idx[2];
   bit m_blank[2];
   pair_t q[$];
   pair_t e;
   always #5 clk = ~clk;
   scan_decoder u4 (.clk(clk), .rst_n(rst_n), .G_n(g_n), .mode(mode), .sel(sel), .load(load),
                    .tick(tick), .Y_n(y4), .idx(idx4), .wrap(wrap4));
   scan_decoder #(.SEL_W(3)) u8 (.clk(clk), .rst_n(rst_n), .G_n(g_n), .mode(mode), .sel(sel3),
                    .load(load), .tick(tick), .Y_n(y8), .idx(idx8), .wrap(wrap8));
   function automatic void chk(string nm, logic [7:0] got, logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endfunction
   // reference: what each output should hold after the coming edge, for an n-line decoder
   function automatic exp_t model(int k, int n, bit g, bit m, int s, bit l, bit t);
      exp_t r;
      bit ch = 0;
      r.wrap = 0;
      if (g) m_blank[k] = 0;
      else if (!m) begin
         m_idx[k] = s;
         m_blank[k] = 0;
      end else begin
         if (l) begin
            m_idx[k] = s;
            ch = 1;
         end else if (t && !(BLANK && m_blank[k])) begin
            r.wrap = m_idx[k] == n - 1;
            m_idx[k] = (m_idx[k] + 1) % n;
            ch = 1;
         end
         m_blank[k] = BLANK && ch;
      end
      r.idx = 3'(m_idx[k]);
      r.y = (g || m_blank[k]) ? 8'hFF : ~(8'd1 << m_idx[k]);
      return r;
   endfunction
   task automatic cyc(bit g, bit m, logic [1:0] s, logic [2:0] s3, bit l, bit t);
      pair_t p;
      @(negedge clk);
      g_n = g; mode = m; sel = s; sel3 = s3; load = l; tick = t;
      p.a = model(0, 4, g, m, s, l, t);
      p.b = model(1, 8, g, m, s3, l, t);
      q.push_back(p);
      @(posedge clk);
   endtask
   task automatic rand_cycles(int n);
      for (int i = 0; i < n; i++)
         cyc($urandom_range(7) == 0, 1'($urandom_range(1)), 2'($urandom), 3'($urandom),
             $urandom_range(3) == 0, 1'($urandom_range(1)));
   endtask
   task automatic model_reset();
      m_idx = '{0, 0};
      m_blank = '{0, 0};
   endtask
   always @(posedge clk) begin
      #1;
      if (rst_n && q.size() != 0) begin
         e = q.pop_front();
         chk("y4", 8'(y4), 8'(e.a.y[3:0]));
         chk("idx4", 8'(idx4), 8'(e.a.idx[1:0]));
         chk("wrap4", 8'(wrap4), 8'(e.a.wrap));
         chk("y8", y8, e.b.y);
         chk("idx8", 8'(idx8), 8'(e.b.idx));
         chk("wrap8", 8'(wrap8), 8'(e.b.wrap));
      end
   end
   initial begin
      model_reset();
      #12;
      chk("rst_y4", 8'(y4), 8'h0F);
      chk("rst_idx4", 8'(idx4), 8'h00);
      chk("rst_wrap8", 8'(wrap8), 8'h00);
      @(negedge clk) rst_n = 1;
      cyc(0, 0, 2'd2, 3'd5, 0, 0);
      #2 chk("dec_y", 8'(y4), 8'h0B);
      cyc(1, 0, 2'd2, 3'd5, 0, 0);
      #2 chk("off_y", 8'(y4), 8'h0F);
      cyc(0, 1, 2'd3, 3'd7, 1, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 1);
      #2 chk("wrap_idx", 8'(idx4), 8'h00);
      chk("wrap_pulse", 8'(wrap4), 8'h01);
      chk("wrap_y", 8'(y4), BLANK ? 8'h0F : 8'h0E);
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
      #2 chk("wrap_drop", 8'(wrap4), 8'h00);
      chk("wrap_y2", 8'(y4), 8'h0E);
      cyc(0, 1, 2'd1, 3'd1, 1, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
      cyc(0, 1, 2'd0, 3'd0, 1, 1);
      #2 chk("ldwin_idx", 8'(idx4), 8'h00);
      chk("ldwin_wrap", 8'(wrap4), 8'h00);
      cyc(0, 1, 2'd0, 3'd0, 1, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 1);
      #2 chk("blank_y", 8'(y4), BLANK ? 8'h0F : 8'h0D);
      cyc(0, 1, 2'd0, 3'd0, 0, 1);
      #2 chk("blank_idx", 8'(idx4), BLANK ? 8'h01 : 8'h02);
      chk("blank_y2", 8'(y4), BLANK ? 8'h0D : 8'h0B);
      cyc(0, 1, 2'd0, 3'd0, 1, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 0);
      wraps = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, 2'd0, 3'd0, 0, 1);
         #2 wraps += int'(wrap8);
         cyc(0, 1, 2'd0, 3'd0, 0, 0);
         #2 wraps += int'(wrap8);
         chk("walk8", y8, ~(8'd1 << (i % 8)));
      end
      chk("walk8_wraps", 8'(wraps), 8'd1);
      rand_cycles(300);
      cyc(0, 1, 2'd2, 3'd6, 1, 0);
      cyc(0, 1, 2'd0, 3'd0, 0, 1);
      cyc(0, 1, 2'd0, 3'd0, 0, 1);
      #3 rst_n = 0;
      #1;
      chk("arst_y4", 8'(y4), 8'h0F);
      chk("arst_idx4", 8'(idx4), 8'h00);
      chk("arst_wrap4", 8'(wrap4), 8'h00);
      chk("arst_y8", y8, 8'hFF);
      chk("arst_idx8", 8'(idx8), 8'h00);
      chk("arst_wrap8", 8'(wrap8), 8'h00);
      g_n = 1; load = 0; tick = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      rand_cycles(200);
      #2 chk("drain", 8'(q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
